// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the SimpleARM instruction fetch stage:
//   RESET_PC_DEFAULT  default PC loaded on reset (word aligned)
//   COND_AL / OP_BRANCH  encodings recognised by the branch predecoder
//   NOP               canonical MOV r0,r0 encoding
//   fetch_reg_t       fetch/decode pipeline register contents
//   branch_target()   pc + 8 + (sign_extend(imm24) << 2), modulo 2^32
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [3:0]  COND_AL          = 4'hE;
    localparam logic [2:0]  OP_BRANCH        = 3'b101;
    localparam logic [31:0] NOP              = 32'hE1A0_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        predicted;
    } fetch_reg_t;

    // B/BL offset is a word offset relative to the R15 read value (pc + 8).
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [23:0] imm24);
        logic [31:0] offset;
        offset = {{6{imm24[23]}}, imm24, 2'b00};
        return pc + 32'd8 + offset;
    endfunction

endpackage

// File: rtl/arm_branch_predecode.sv
// ---------------------------------------------------------------------------
// arm_branch_predecode
// Combinational detection of unconditional (AL) B/BL in the word just
// returned by instruction memory, plus its branch target.
//   pc      in  32  address the instruction was fetched from
//   instr   in  32  instruction word
//   hit     out 1   instr is an AL-conditioned B or BL
//   target  out 32  branch destination (valid only when hit)
// Conditional branches never hit; execute resolves them.
// ---------------------------------------------------------------------------
module arm_branch_predecode
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        hit,
    output logic [31:0] target
);

    // B and BL redirect identically; the link bit only matters to execute.
    logic unused_link_bit;
    assign unused_link_bit = instr[24];

    assign hit    = (instr[31:28] == COND_AL) && (instr[27:25] == OP_BRANCH);
    assign target = branch_target(pc, instr[23:0]);

endmodule

// File: rtl/arm_fetch_stage.sv
// ---------------------------------------------------------------------------
// arm_fetch_stage
// Instruction fetch stage for the SimpleARM core. Owns the PC, drives the
// instruction memory address and captures the returned word into the
// fetch/decode register with its PC, PC+4 (link) and PC+8 (R15 read).
//
// Ports:
//   clk          in  1   rising-edge clock
//   reset        in  1   synchronous active-high reset
//   imem_addr    out 32  current PC (straight from the register)
//   imem_rd      in  32  instruction word for imem_addr, same cycle
//   stall        in  1   hold PC and fetch register
//   redirect     in  1   branch taken in execute: flush and load redirect_pc
//   redirect_pc  in  32  branch target, low two bits forced to 00
//   if_valid     out 1   fetch register holds a live instruction
//   if_instr     out 32  captured instruction
//   if_pc        out 32  address of if_instr
//   if_pc_plus4  out 32  if_pc + 4
//   if_pc_plus8  out 32  if_pc + 8
//   if_predicted out 1   if_instr already redirected by fetch predecode
//
// Build option: define FETCH_PREDECODE_EN to redirect AL B/BL from fetch
// with zero bubbles. Without it the next PC is always pc+4 and
// if_predicted is tied 0.
// ---------------------------------------------------------------------------
module arm_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_pc_plus8,
    output logic        if_predicted
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    fetch_reg_t  fetch_reg;
    fetch_reg_t  fetch_next;

    // Next PC when neither redirect nor stall applies.
    logic        seq_hit;
    logic [31:0] seq_pc;

`ifdef FETCH_PREDECODE_EN
    logic [31:0] predecode_target;

    arm_branch_predecode u_predecode (
        .pc     (pc_reg),
        .instr  (imem_rd),
        .hit    (seq_hit),
        .target (predecode_target)
    );

    assign seq_pc = seq_hit ? predecode_target : pc_reg + 32'd4;
`else
    assign seq_hit = 1'b0;
    assign seq_pc  = pc_reg + 32'd4;
`endif

    always_comb begin
        pc_next    = seq_pc;
        fetch_next = fetch_reg;
        if (redirect) begin
            // Flush whatever is being fetched; redirect outranks stall.
            pc_next          = redirect_pc & ~32'h3;
            fetch_next.valid = 1'b0;
        end else if (stall) begin
            pc_next = pc_reg;
        end else begin
            fetch_next.valid     = 1'b1;
            fetch_next.instr     = imem_rd;
            fetch_next.pc        = pc_reg;
            fetch_next.predicted = seq_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            fetch_reg <= '0;
        end else begin
            pc_reg    <= pc_next;
            fetch_reg <= fetch_next;
        end
    end

    assign imem_addr    = pc_reg;
    assign if_valid     = fetch_reg.valid;
    assign if_instr     = fetch_reg.instr;
    assign if_pc        = fetch_reg.pc;
    assign if_predicted = fetch_reg.predicted;
    assign if_pc_plus4  = fetch_reg.pc + 32'd4;
    assign if_pc_plus8  = fetch_reg.pc + 32'd8;

endmodule

// File: tb/tb_arm_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_arm_fetch_stage
// Directed bench for arm_fetch_stage. Instruction memory is modelled
// combinationally: NOP everywhere, or (prog_mode) a small branch program
// with BL at 0x0, BEQ at 0x8 and "B ." at 0x10.
// ---------------------------------------------------------------------------
module tb_arm_fetch_stage;
    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_pc_plus8;
    logic        if_predicted;

    logic        prog_mode;
    int          n_cmp;
    int          n_bad;

    arm_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_rd      (imem_rd),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc_plus4  (if_pc_plus4),
        .if_pc_plus8  (if_pc_plus8),
        .if_predicted (if_predicted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_rd = NOP;
        if (prog_mode) begin
            case (imem_addr)
                32'h0000_0000: imem_rd = 32'hEB00_0000;  // BL  +0 -> 0x8
                32'h0000_0008: imem_rd = 32'h0AFF_FFFE;  // BEQ (never predicted)
                32'h0000_0010: imem_rd = 32'hEAFF_FFFE;  // B . -> 0x10
                default:       imem_rd = NOP;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
        $display("check %-22s observed %08h expected %08h", tag, obs, exp);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        prog_mode   = 1'b0;
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset held two cycles.
        tick();
        check("rst1_valid", {31'd0, if_valid}, 32'd0);
        tick();
        check("rst2_valid", {31'd0, if_valid}, 32'd0);
        check("rst2_addr", imem_addr, 32'h0);
        check("rst2_pc", if_pc, 32'h0);
        check("rst2_instr", if_instr, 32'h0);
        check("rst2_pred", {31'd0, if_predicted}, 32'd0);

        // First cycle after release: fetching RESET_PC, nothing valid yet.
        reset = 1'b0;
        check("rel_addr", imem_addr, 32'h0);
        check("rel_valid", {31'd0, if_valid}, 32'd0);
        tick();
        check("seq0_addr", imem_addr, 32'h4);
        check("seq0_valid", {31'd0, if_valid}, 32'd1);
        check("seq0_pc", if_pc, 32'h0);
        check("seq0_plus4", if_pc_plus4, 32'h4);
        check("seq0_plus8", if_pc_plus8, 32'h8);
        check("seq0_instr", if_instr, NOP);
        tick();
        check("seq1_addr", imem_addr, 32'h8);
        check("seq1_pc", if_pc, 32'h4);

        // Stall for three cycles at imem_addr 0x8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr", imem_addr, 32'h8);
            check("stall_pc", if_pc, 32'h4);
            check("stall_instr", if_instr, NOP);
            check("stall_valid", {31'd0, if_valid}, 32'd1);
        end
        stall = 1'b0;
        tick();
        check("unstall_pc", if_pc, 32'h8);
        check("unstall_addr", imem_addr, 32'hC);

        // Redirect with misaligned target: low bits dropped, one bubble.
        redirect    = 1'b1;
        redirect_pc = 32'h23;
        tick();
        check("redir_addr", imem_addr, 32'h20);
        check("redir_valid", {31'd0, if_valid}, 32'd0);
        redirect = 1'b0;
        tick();
        check("redir_pc", if_pc, 32'h20);
        check("redir_valid2", {31'd0, if_valid}, 32'd1);
        check("redir_addr2", imem_addr, 32'h24);

        // Redirect outranks stall.
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h40;
        tick();
        check("rs_addr", imem_addr, 32'h40);
        check("rs_valid", {31'd0, if_valid}, 32'd0);
        stall = 1'b0;

        // Continuous redirect re-targets every cycle, valid stays low.
        redirect_pc = 32'h100;
        tick();
        check("cont1_addr", imem_addr, 32'h100);
        check("cont1_valid", {31'd0, if_valid}, 32'd0);
        redirect_pc = 32'h200;
        tick();
        check("cont2_addr", imem_addr, 32'h200);
        check("cont2_valid", {31'd0, if_valid}, 32'd0);

        // PC wrap at the top of the address space.
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        tick();
        check("wrap_addr1", imem_addr, 32'h0);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", if_pc_plus4, 32'h0);
        check("wrap_plus8", if_pc_plus8, 32'h4);

        // Branch program, restarted through reset.
        prog_mode = 1'b1;
        reset     = 1'b1;
        tick();
        check("prst_valid", {31'd0, if_valid}, 32'd0);
        reset = 1'b0;
        check("prog_addr0", imem_addr, 32'h0);
        tick();
`ifdef FETCH_PREDECODE_EN
        check("bl_addr", imem_addr, 32'h8);
        check("bl_pc", if_pc, 32'h0);
        check("bl_pred", {31'd0, if_predicted}, 32'd1);
        check("bl_plus4", if_pc_plus4, 32'h4);
        check("bl_instr", if_instr, 32'hEB00_0000);
        tick();
        check("beq_addr", imem_addr, 32'hC);
        check("beq_pc", if_pc, 32'h8);
        check("beq_pred", {31'd0, if_predicted}, 32'd0);
        tick();
        check("p_c_addr", imem_addr, 32'h10);
        tick();
        check("bself_addr", imem_addr, 32'h10);
        check("bself_pc", if_pc, 32'h10);
        check("bself_pred", {31'd0, if_predicted}, 32'd1);
`else
        check("bl_addr", imem_addr, 32'h4);
        check("bl_pc", if_pc, 32'h0);
        check("bl_pred", {31'd0, if_predicted}, 32'd0);
        check("bl_instr", if_instr, 32'hEB00_0000);
        tick();
        check("np4_addr", imem_addr, 32'h8);
        check("np4_pc", if_pc, 32'h4);
        tick();
        check("beq_addr", imem_addr, 32'hC);
        check("beq_pc", if_pc, 32'h8);
        check("beq_pred", {31'd0, if_predicted}, 32'd0);
        check("beq_instr", if_instr, 32'h0AFF_FFFE);
        tick();
        check("p_c_addr", imem_addr, 32'h10);
        tick();
        check("bself_addr", imem_addr, 32'h14);
        check("bself_pc", if_pc, 32'h10);
        check("bself_pred", {31'd0, if_predicted}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arm_fetch_stage.md
# arm_fetch_stage

Instruction fetch stage for the SimpleARM core. It owns the program counter and drives the word-aligned instruction memory address. It captures the returned instruction into a fetch/decode pipeline register, together with its PC and the derived PC+4 (link) and PC+8 (R15 read) values. It honours a stall from decode and a branch redirect/flush from execute, and can optionally predecode unconditional B/BL to redirect with zero bubbles.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_addr  out  32  fetch address (current PC), to instruction memory `a`
- imem_rd  in  32  instruction word, combinational from imem_addr in the same cycle
- stall  in  1  hold PC and fetch register
- redirect  in  1  branch taken in execute; flush and load redirect_pc
- redirect_pc  in  32  branch target; bits [1:0] ignored (forced 00)
- if_valid  out  1  fetch register holds a live instruction
- if_instr  out  32  captured instruction
- if_pc  out  32  address of if_instr
- if_pc_plus4  out  32  if_pc + 4 (BL link value)
- if_pc_plus8  out  32  if_pc + 8 (architectural R15 read)
- if_predicted  out  1  if_instr already redirected by fetch predecode

## Operation
- State: pc register, fetch register {valid, instr, pc, predicted}.
- imem_addr = pc, driven directly from the register with no combinational path from inputs.
- Next-pc priority, highest first: reset → RESET_PC; redirect → {redirect_pc[31:2],2'b00}; stall → pc; predecode hit → branch target; else pc+4.
- Fetch register update, same priority:
  - reset → valid=0, instr=0, pc=0, predicted=0.
  - redirect → valid=0 (flush); other fields don't-care. Redirect wins over stall.
  - stall → hold all fields.
  - else → valid=1, instr=imem_rd, pc=pc, predicted=hit.
- if_pc_plus4/if_pc_plus8 are combinational from the registered if_pc.
- All adds are 32-bit modulo 2^32. PC wrap 0xFFFF_FFFC → 0x0000_0000 is legal and silent.
- After reset deassertion, the first cycle fetches RESET_PC with if_valid=0. The first valid instruction appears one cycle later.
- Reset mid-operation discards the fetch register and any pending redirect.
- Contract with execute: execute must not assert redirect for an instruction delivered with if_predicted=1.

## Timing
- One-cycle latency: the address presented in cycle N appears on if_* in cycle N+1.
- Redirect sampled in cycle N:
  - imem_addr = target in N+1, with if_valid=0 in N+1.
  - First target instruction is valid in N+2.
  - Cost: one bubble.
- Predecode hit at pc P in cycle N: imem_addr = target in N+1, and the branch is valid on if_* in N+1. Zero bubbles.
- Stall asserted in cycle N: PC and if_* in N+1 are identical to N. Throughput resumes the cycle after stall drops.
- Redirect is not itself registered or delayed. A continuous redirect re-targets every cycle with if_valid held 0.

## Configuration
- FETCH_PREDECODE_EN defined:
  - Hit condition: imem_rd[31:28]==4'hE and imem_rd[27:25]==3'b101, i.e. AL-conditioned B or BL.
  - Target = pc + 8 + (sign_extend(imm24) << 2).
  - if_predicted reflects the hit.
  - Conditional branches never hit.
- FETCH_PREDECODE_EN undefined:
  - No predecode logic; next pc is always pc+4 absent redirect/stall.
  - if_predicted is tied 0.

## Structure
- Shared package fetch_pkg holds:
  - RESET_PC default.
  - COND_AL=4'hE and OP_BRANCH=3'b101.
  - NOP=32'hE1A00000.
  - A fetch-register struct typedef.
  - A branch_target(pc, imm24) function.
- One sub-module, arm_branch_predecode: combinational hit/target from (pc, instr). Instantiated only under FETCH_PREDECODE_EN.

## Test plan
- Reset held 2 cycles, then released, with imem returning NOP everywhere → imem_addr 0,4,8,…; if_valid=0 during reset and in the first cycle after; then if_pc=0, if_pc_plus4=4, if_pc_plus8=8.
- stall held 3 cycles while imem_addr=0x8 → imem_addr stays 0x8 and if_pc/if_instr stay frozen at 0x4; on release, if_pc=0x8 next cycle.
- redirect=1, redirect_pc=0x23 → imem_addr=0x20 next cycle with if_valid=0, then if_pc=0x20 and if_valid=1.
- redirect and stall both asserted, redirect_pc=0x40 → redirect wins: imem_addr=0x40, if_valid=0.
- Instruction memory with 0xEB000000 (BL) at 0x0 and 0x0AFFFFFE (BEQ) at 0x8:
  - With FETCH_PREDECODE_EN: imem_addr 0x0 → 0x8; if_pc=0, if_predicted=1, if_pc_plus4=4; the BEQ at 0x8 is not predicted, so the next address is 0xC.
  - Without FETCH_PREDECODE_EN: addresses 0x0, 0x4, 0x8; if_predicted always 0.
- redirect_pc=0xFFFFFFFC with no further redirect → imem_addr 0xFFFFFFFC, then 0x00000000; if_pc_plus8 of 0xFFFFFFFC = 0x00000004.
